// File: rtl/rsub_pkg.sv
// Shared FSM encoding and default operand width for the serial borrow subtractor.
package rsub_pkg;

  localparam int RSUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rsub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit underflows.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_ripple_borrow_subtractor.sv
// Bit-serial a - b - b_in, LSB first, one bit per clock; done pulses WIDTH+1 cycles after start.
// No backpressure: start is only accepted in IDLE and is ignored while busy.
module serial_ripple_borrow_subtractor
  import rsub_pkg::*;
#(
  parameter int WIDTH = RSUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rsub_state_t      state_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q, acc_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q, br_d, d_bit;
  logic             bout_q, busy_q, done_q;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (d_bit),
    .bout (br_d)
  );

  // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign acc_d = {d_bit, acc_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            br_q    <= b_in;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          br_q  <= br_d;
          acc_q <= acc_d;
          if (cnt_q == LAST) begin
            diff_q  <= acc_d;
            bout_q  <= br_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
